// File: rtl/clkena_nco_pkg.sv
// Shared types for the clock-enable NCO bank: config FSM states and channel-index width.
package clkena_nco_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, ERR} cfg_state_e;

  function automatic int calc_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkena_nco_chan.sv
// One fractional-N clock-enable channel: acc steps by mul, wraps by div, pulse on wrap.
module clkena_nco_chan #(
  parameter int RATIO_W  = 16,
  parameter int LOCK_CNT = 4,
  parameter int DEF_MUL  = 1,
  parameter int DEF_DIV  = 2
) (
  input  logic               inclk0,
  input  logic               reset,
  input  logic               load,
  input  logic [RATIO_W-1:0] load_mul,
  input  logic [RATIO_W-1:0] load_div,
  output logic               clkena,
  output logic               locked
);

  localparam int LC_W = $clog2(LOCK_CNT + 1);

  logic [RATIO_W-1:0] mul_q, mul_d, div_q, div_d;
  logic [RATIO_W:0]   acc_q, acc_d, sum;
  logic [LC_W-1:0]    lcnt_q, lcnt_d;
  logic               clkena_q, clkena_d, locked_q, locked_d;

  always_comb begin
    mul_d    = mul_q;
    div_d    = div_q;
    acc_d    = '0;
    clkena_d = 1'b0;
    lcnt_d   = lcnt_q;
    sum      = acc_q + {1'b0, mul_q};
    if (load) begin
      // a pulse that would fire on the load cycle is intentionally dropped
      mul_d  = load_mul;
      div_d  = load_div;
      lcnt_d = '0;
    end else if (mul_q != '0) begin
      if (sum >= {1'b0, div_q}) begin
        acc_d    = sum - {1'b0, div_q};
        clkena_d = 1'b1;
        if (lcnt_q != LC_W'(LOCK_CNT)) lcnt_d = lcnt_q + LC_W'(1);
      end else begin
        acc_d = sum;
      end
    end
    locked_d = (lcnt_d == LC_W'(LOCK_CNT));
  end

  always_ff @(posedge inclk0) begin
    if (reset) begin
      mul_q    <= RATIO_W'(DEF_MUL);
      div_q    <= RATIO_W'(DEF_DIV);
      acc_q    <= '0;
      lcnt_q   <= '0;
      clkena_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      mul_q    <= mul_d;
      div_q    <= div_d;
      acc_q    <= acc_d;
      lcnt_q   <= lcnt_d;
      clkena_q <= clkena_d;
      locked_q <= locked_d;
    end
  end

  assign clkena = clkena_q;
  assign locked = locked_q;

endmodule

// File: rtl/clkena_nco_bank.sv
// Bank of NUM_CH clock-enable NCOs with a valid/ready reconfiguration port and lock flags.
module clkena_nco_bank import clkena_nco_pkg::*; #(
  parameter int  NUM_CH   = 6,
  parameter int  RATIO_W  = 16,
  parameter int  LOCK_CNT = 4,
  parameter int  DEF_MUL  = 1,
  parameter int  DEF_DIV  = 2,
  localparam int CH_W     = calc_ch_w(NUM_CH)
) (
  input  logic               inclk0,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [RATIO_W-1:0] cfg_mul,
  input  logic [RATIO_W-1:0] cfg_div,
  output logic               cfg_err,
  output logic [NUM_CH-1:0]  clkena,
  output logic [NUM_CH-1:0]  locked,
  output logic               all_locked
);

  cfg_state_e         state_q, state_d;
  logic               ready_q, ready_d, err_q, err_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [RATIO_W-1:0] req_mul_q, req_mul_d, req_div_q, req_div_d;
  logic               req_bad;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    req_mul_d = req_mul_q;
    req_div_d = req_div_q;
    req_bad   = (req_div_q == '0) || (req_mul_q > req_div_q) || (32'(ch_q) >= NUM_CH);
    case (state_q)
      IDLE: if (cfg_valid && ready_q) begin
        state_d   = CHECK;
        ch_d      = cfg_ch;
        req_mul_d = cfg_mul;
        req_div_d = cfg_div;
      end
      CHECK:   state_d = req_bad ? ERR : APPLY;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    err_d   = (state_q == ERR);
  end

  always_ff @(posedge inclk0) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      ch_q      <= '0;
      req_mul_q <= '0;
      req_div_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      ch_q      <= ch_d;
      req_mul_q <= req_mul_d;
      req_div_q <= req_div_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkena_nco_chan #(
      .RATIO_W (RATIO_W),
      .LOCK_CNT(LOCK_CNT),
      .DEF_MUL (DEF_MUL),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .inclk0  (inclk0),
      .reset   (reset),
      .load    ((state_q == APPLY) && (ch_q == CH_W'(i))),
      .load_mul(req_mul_q),
      .load_div(req_div_q),
      .clkena  (clkena[i]),
      .locked  (locked[i])
    );
  end

  assign cfg_ready  = ready_q;
  assign cfg_err    = err_q;
  assign all_locked = &locked;

endmodule

// File: tb/tb_clkena_nco_bank.sv
// Checks the NCO bank against a floor(n*mul/div) pulse-count model and a request timeline model.
module tb_clkena_nco_bank;

  localparam int NUM_CH   = 6;
  localparam int RATIO_W  = 16;
  localparam int LOCK_CNT = 4;
  localparam int CH_W     = 3;

  logic               inclk0 = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_valid = 1'b0;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [RATIO_W-1:0] cfg_mul = '0, cfg_div = '0;
  logic               cfg_ready, cfg_err, all_locked;
  logic [NUM_CH-1:0]  clkena, locked;

  int errors = 0;
  int checks = 0;

  always #5 inclk0 = ~inclk0;

  clkena_nco_bank #(
    .NUM_CH(NUM_CH), .RATIO_W(RATIO_W), .LOCK_CNT(LOCK_CNT), .DEF_MUL(1), .DEF_DIV(2)
  ) dut (
    .inclk0    (inclk0),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mul   (cfg_mul),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clkena    (clkena),
    .locked    (locked),
    .all_locked(all_locked)
  );

  // Reference model: n = cycles accumulated since load, pc = pulses since load.
  longint            m[NUM_CH], d[NUM_CH], n[NUM_CH], pc[NUM_CH];
  logic [NUM_CH-1:0] e_clk = '0, e_lock = '0;
  logic              e_ready = 1'b0, e_err = 1'b0, accepted = 1'b0;
  int                stage = 0, p_ch = 0;
  longint            p_mul = 0, p_div = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic v, input logic r);
    logic ok;
    accepted = 1'b0;
    if (r) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m[c] = 1; d[c] = 2; n[c] = 0; pc[c] = 0;
      end
      e_clk = '0; e_ready = 1'b0; e_err = 1'b0; stage = 0;
    end else begin
      ok    = (p_div != 0) && (p_mul <= p_div) && (p_ch < NUM_CH);
      e_err = (stage == 2) && !ok;
      for (int c = 0; c < NUM_CH; c++) begin
        if (stage == 2 && ok && c == p_ch) begin
          m[c] = p_mul; d[c] = p_div; n[c] = 0; pc[c] = 0; e_clk[c] = 1'b0;
        end else begin
          n[c]++;
          e_clk[c] = (m[c] != 0) && ((n[c] * m[c]) / d[c] > ((n[c] - 1) * m[c]) / d[c]);
          if (e_clk[c]) pc[c]++;
        end
      end
      if (stage == 2) begin
        stage = 0; e_ready = 1'b1;
      end else if (stage == 1) begin
        stage = 2;
      end else if (v && e_ready) begin
        stage = 1; e_ready = 1'b0; accepted = 1'b1;
        p_ch = int'(cfg_ch); p_mul = longint'(cfg_mul); p_div = longint'(cfg_div);
      end else begin
        e_ready = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) e_lock[c] = (pc[c] >= LOCK_CNT);
  endtask

  task automatic tick();
    logic v, r;
    v = cfg_valid;
    r = reset;
    @(posedge inclk0);
    model_edge(v, r);
    #1;
    chk("clkena", 32'(clkena), 32'(e_clk));
    chk("locked", 32'(locked), 32'(e_lock));
    chk("all_locked", 32'(all_locked), 32'(&e_lock));
    chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic send(input int ch, input int mul, input int div);
    int t;
    cfg_ch = CH_W'(ch); cfg_mul = RATIO_W'(mul); cfg_div = RATIO_W'(div);
    cfg_valid = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (!accepted && t < 20);
    cfg_valid = 1'b0;
    if (!accepted) begin
      errors++;
      $display("FAIL handshake observed=not_accepted expected=accepted_within_20");
    end
  endtask

  initial begin
    int cnt, dv, mv, sel;
    // reset state
    reset = 1'b1;
    ticks(3);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    reset = 1'b0;
    // defaults 1/2: pulses every other edge, lock at edge 8
    ticks(12);
    chk("def_all_locked", 32'(all_locked), 32'd1);

    // ch2 -> 3/8: exactly 3 pulses in the first 8 accumulating cycles
    send(2, 3, 8);
    ticks(2);
    chk("ch2_locked_drop", 32'(locked[2]), 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt += int'(clkena[2]);
    end
    chk("ch2_pulses_per_8", 32'(cnt), 32'd3);
    ticks(40);

    // rejected requests: mul>div, div=0, ch out of range
    send(1, 5, 4);
    ticks(3);
    send(3, 0, 0);
    ticks(3);
    send(7, 1, 2);
    ticks(5);

    // silent channel
    send(0, 0, 1);
    ticks(50);
    chk("ch0_silent_all_locked", 32'(all_locked), 32'd0);

    // ratio boundaries at full width
    send(4, 65535, 65535);
    send(5, 65534, 65535);
    send(0, 1, 65535);
    ticks(200);

    // reset during CHECK, then during APPLY
    send(1, 1, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(12);
    send(3, 1, 3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ticks(12);

    // randomized requests, some held back-to-back, occasional reset
    for (int it = 0; it < 150; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      dv = 0;
      else if (sel == 1) dv = 65535;
      else               dv = int'($urandom_range(1, 20));
      mv = int'($urandom_range(0, dv + 1));
      if (mv > 65535) mv = 65535;
      send(int'($urandom_range(0, 7)), mv, dv);
      ticks(int'($urandom_range(0, 6)));
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    ticks(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
